// File: rtl/byte_word_packer_if.sv
// Byte-stream input and packed-word write bus shared by the packer and its environment.
interface byte_word_packer_if #(
  parameter int BYTES_PER_WORD = 20,
  parameter int ADDR_W         = 8
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [7:0]                  in_data;
  logic                        in_last;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [8*BYTES_PER_WORD-1:0] wr_data;
  logic [CNT_W-1:0]            wr_bytes;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, wr_bytes
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, wr_bytes
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into BYTES_PER_WORD-wide words written to an
// image buffer at incrementing addresses, with line/frame sync pulses,
// partial-word flush on in_last, wrap/stop addressing and a synchronous clear.
module byte_word_packer #(
  parameter int BYTES_PER_WORD = 20,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int H_SYNC         = 255,
  parameter int V_SYNC         = 255,
  parameter bit MSB_FIRST      = 1'b0,
  parameter bit WRAP           = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  byte_word_packer_if.slave bus,
  output logic              hsync,
  output logic              vsync,
  output logic              done,
  output logic              overflow
);
  localparam int CNT_W   = $clog2(BYTES_PER_WORD + 1);
  localparam int WORD_W  = 8 * BYTES_PER_WORD;
  localparam int LINE_W  = (H_SYNC > 1) ? $clog2(H_SYNC) : 1;
  localparam int FRAME_W = (V_SYNC > 1) ? $clog2(V_SYNC) : 1;

  typedef enum logic [1:0] {ACTIVE, DONE, FULL} state_t;

  state_t             state;
  logic [WORD_W-1:0]  asm_word;
  logic [WORD_W-1:0]  next_word;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   lane;
  logic [ADDR_W-1:0]  addr;
  logic [LINE_W-1:0]  line_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               accept;
  logic               word_full;
  logic               commit;
  logic               at_end;
  logic               line_end;
  logic               frame_end;

  // Ready is held low while reset is asserted and during a clear cycle.
  assign bus.in_ready = reset && (state == ACTIVE) && !clear;
  assign accept       = bus.in_valid && bus.in_ready;
  assign word_full    = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign commit       = accept && (word_full || bus.in_last);
  assign at_end       = (addr == ADDR_W'(DEPTH - 1));
  assign line_end     = (line_cnt == LINE_W'(H_SYNC - 1));
  assign frame_end    = (frame_cnt == FRAME_W'(V_SYNC - 1));

  // Merge the incoming byte into its lane so a committing byte is part of the written word.
  always_comb begin
    lane      = MSB_FIRST ? (CNT_W'(BYTES_PER_WORD - 1) - byte_cnt) : byte_cnt;
    next_word = asm_word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == CNT_W'(i)) next_word[8*i +: 8] = bus.in_data;
    end
  end

  // Control FSM with registered write port, sync pulses and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ACTIVE;
      asm_word     <= '0;
      byte_cnt     <= '0;
      addr         <= '0;
      line_cnt     <= '0;
      frame_cnt    <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.wr_bytes <= '0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      if (clear) begin
        state     <= ACTIVE;
        asm_word  <= '0;
        byte_cnt  <= '0;
        addr      <= '0;
        line_cnt  <= '0;
        frame_cnt <= '0;
        done      <= 1'b0;
        overflow  <= 1'b0;
      end else if (accept) begin
        if (commit) begin
          bus.wr_en    <= 1'b1;
          bus.wr_addr  <= addr;
          bus.wr_data  <= next_word;
          bus.wr_bytes <= byte_cnt + CNT_W'(1);
          asm_word     <= '0;
          byte_cnt     <= '0;
          if (!at_end) begin
            addr <= addr + ADDR_W'(1);
          end else if (WRAP) begin
            addr <= '0;
          end else begin
            overflow <= 1'b1;
            state    <= FULL;
          end
          // A final byte that also fills the buffer reports DONE rather than FULL.
          if (bus.in_last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end else begin
          asm_word <= next_word;
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
        if (line_end) begin
          line_cnt <= '0;
          hsync    <= 1'b1;
          if (frame_end) begin
            frame_cnt <= '0;
            vsync     <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
          end
        end else begin
          line_cnt <= line_cnt + LINE_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: four instances cover LSB/MSB lane order,
// buffer stop and wrap, sync pulses, clear and mid-word reset.
module tb_byte_word_packer;
  localparam int BPW  [4] = '{4, 4, 1, 1};
  localparam int DEP  [4] = '{256, 256, 4, 4};
  localparam int HS   [4] = '{3, 255, 255, 255};
  localparam int VS   [4] = '{2, 255, 255, 255};
  localparam bit MSBF [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit WRP  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
    int          addr;
    int          bytes;
    bit          done;
    bit          ovf;
  } wrExp_t;

  typedef struct {
    int dut;
    int due;
    bit vs;
  } syncExp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inValid [4];
  logic       inLast  [4];
  logic [7:0] inData  [4];
  logic       clearIn [4];

  wire        obsReady [4];
  wire        obsWrEn  [4];
  wire [7:0]  obsAddr  [4];
  wire [31:0] obsData  [4];
  wire [2:0]  obsBytes [4];
  wire        obsHs    [4];
  wire        obsVs    [4];
  wire        obsDone  [4];
  wire        obsOvf   [4];

  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;

  wrExp_t   wrQ[$];
  syncExp_t syQ[$];

  logic [31:0] mAsm   [4];
  int          mCnt   [4];
  int          mAddr  [4];
  int          mState [4];
  int          mLine  [4];
  int          mFrame [4];
  bit          mDone  [4];
  bit          mOvf   [4];

  byte_word_packer_if #(.BYTES_PER_WORD(4), .ADDR_W(8)) if0 ();
  byte_word_packer_if #(.BYTES_PER_WORD(4), .ADDR_W(8)) if1 ();
  byte_word_packer_if #(.BYTES_PER_WORD(1), .ADDR_W(2)) if2 ();
  byte_word_packer_if #(.BYTES_PER_WORD(1), .ADDR_W(2)) if3 ();

  assign if0.in_valid = inValid[0];
  assign if0.in_data  = inData[0];
  assign if0.in_last  = inLast[0];
  assign if1.in_valid = inValid[1];
  assign if1.in_data  = inData[1];
  assign if1.in_last  = inLast[1];
  assign if2.in_valid = inValid[2];
  assign if2.in_data  = inData[2];
  assign if2.in_last  = inLast[2];
  assign if3.in_valid = inValid[3];
  assign if3.in_data  = inData[3];
  assign if3.in_last  = inLast[3];

  assign obsReady[0] = if0.in_ready;
  assign obsReady[1] = if1.in_ready;
  assign obsReady[2] = if2.in_ready;
  assign obsReady[3] = if3.in_ready;
  assign obsWrEn[0]  = if0.wr_en;
  assign obsWrEn[1]  = if1.wr_en;
  assign obsWrEn[2]  = if2.wr_en;
  assign obsWrEn[3]  = if3.wr_en;
  assign obsAddr[0]  = if0.wr_addr;
  assign obsAddr[1]  = if1.wr_addr;
  assign obsAddr[2]  = {6'b0, if2.wr_addr};
  assign obsAddr[3]  = {6'b0, if3.wr_addr};
  assign obsData[0]  = if0.wr_data;
  assign obsData[1]  = if1.wr_data;
  assign obsData[2]  = {24'b0, if2.wr_data};
  assign obsData[3]  = {24'b0, if3.wr_data};
  assign obsBytes[0] = if0.wr_bytes;
  assign obsBytes[1] = if1.wr_bytes;
  assign obsBytes[2] = {2'b0, if2.wr_bytes};
  assign obsBytes[3] = {2'b0, if3.wr_bytes};

  byte_word_packer #(.BYTES_PER_WORD(4), .ADDR_W(8), .DEPTH(256), .H_SYNC(3), .V_SYNC(2),
                     .MSB_FIRST(1'b0), .WRAP(1'b0)) u0 (
    .clk(clk), .reset(reset), .clear(clearIn[0]), .bus(if0),
    .hsync(obsHs[0]), .vsync(obsVs[0]), .done(obsDone[0]), .overflow(obsOvf[0]));

  byte_word_packer #(.BYTES_PER_WORD(4), .ADDR_W(8), .DEPTH(256), .H_SYNC(255), .V_SYNC(255),
                     .MSB_FIRST(1'b1), .WRAP(1'b0)) u1 (
    .clk(clk), .reset(reset), .clear(clearIn[1]), .bus(if1),
    .hsync(obsHs[1]), .vsync(obsVs[1]), .done(obsDone[1]), .overflow(obsOvf[1]));

  byte_word_packer #(.BYTES_PER_WORD(1), .ADDR_W(2), .DEPTH(4), .H_SYNC(255), .V_SYNC(255),
                     .MSB_FIRST(1'b0), .WRAP(1'b0)) u2 (
    .clk(clk), .reset(reset), .clear(clearIn[2]), .bus(if2),
    .hsync(obsHs[2]), .vsync(obsVs[2]), .done(obsDone[2]), .overflow(obsOvf[2]));

  byte_word_packer #(.BYTES_PER_WORD(1), .ADDR_W(2), .DEPTH(4), .H_SYNC(255), .V_SYNC(255),
                     .MSB_FIRST(1'b0), .WRAP(1'b1)) u3 (
    .clk(clk), .reset(reset), .clear(clearIn[3]), .bus(if3),
    .hsync(obsHs[3]), .vsync(obsVs[3]), .done(obsDone[3]), .overflow(obsOvf[3]));

  // Free-running clock and cycle stamp used to time expected outputs.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Return a reference model to its post-reset / post-clear state.
  task automatic modelReset(input int d);
    mAsm[d]   = '0;
    mCnt[d]   = 0;
    mAddr[d]  = 0;
    mState[d] = 0;
    mLine[d]  = 0;
    mFrame[d] = 0;
    mDone[d]  = 1'b0;
    mOvf[d]   = 1'b0;
  endtask

  // Reference behaviour for one accepted byte; queues the write and sync events it causes.
  task automatic modelAccept(input int d, input logic [7:0] data, input bit last);
    int       lane;
    wrExp_t   e;
    syncExp_t s;
    lane = MSBF[d] ? (BPW[d] - 1 - mCnt[d]) : mCnt[d];
    mAsm[d][8*lane +: 8] = data;
    mCnt[d]++;
    if ((mCnt[d] == BPW[d]) || last) begin
      e.dut   = d;
      e.due   = cyc + 1;
      e.data  = mAsm[d];
      e.addr  = mAddr[d];
      e.bytes = mCnt[d];
      if (mAddr[d] < DEP[d] - 1) mAddr[d]++;
      else if (WRP[d]) mAddr[d] = 0;
      else begin
        mOvf[d]   = 1'b1;
        mState[d] = 2;
      end
      if (last) begin
        mDone[d]  = 1'b1;
        mState[d] = 1;
      end
      e.done = mDone[d];
      e.ovf  = mOvf[d];
      wrQ.push_back(e);
      mAsm[d] = '0;
      mCnt[d] = 0;
    end
    mLine[d]++;
    if (mLine[d] == HS[d]) begin
      mLine[d] = 0;
      mFrame[d]++;
      s.dut = d;
      s.due = cyc + 1;
      s.vs  = 1'b0;
      if (mFrame[d] == VS[d]) begin
        mFrame[d] = 0;
        s.vs      = 1'b1;
      end
      syQ.push_back(s);
    end
  endtask

  // Offer one byte for one cycle; reports whether the model expects it to be taken.
  task automatic applyStimulus(input int d, input logic [7:0] data, input bit last,
                               input bit valid, output bit taken);
    bit expReady;
    @(negedge clk);
    inValid[d] = valid;
    inData[d]  = data;
    inLast[d]  = last;
    #1;
    expReady = (mState[d] == 0);
    checkOutput($sformatf("in_ready_u%0d", d), obsReady[d], expReady);
    taken = valid && expReady;
    if (taken) modelAccept(d, data, last);
    @(posedge clk);
  endtask

  // Stream a run of bytes with in_valid held high; in_last optionally on the final byte.
  task automatic streamBytes(input int d, input logic [7:0] first, input int count, input bit lastOnEnd);
    bit taken;
    for (int i = 0; i < count; i++) begin
      applyStimulus(d, first + 8'(i), lastOnEnd && (i == count - 1), 1'b1, taken);
    end
  endtask

  // Idle all inputs for a number of cycles.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        inValid[d] = 1'b0;
        inLast[d]  = 1'b0;
      end
    end
  endtask

  // One-cycle clear with a byte offered at the same time, which must not be taken.
  task automatic pulseClear(input int d);
    @(negedge clk);
    clearIn[d] = 1'b1;
    inValid[d] = 1'b1;
    inData[d]  = 8'hEE;
    inLast[d]  = 1'b0;
    #1;
    checkOutput($sformatf("ready_in_clear_u%0d", d), obsReady[d], 1'b0);
    @(posedge clk);
    modelReset(d);
    #1;
    clearIn[d] = 1'b0;
    inValid[d] = 1'b0;
  endtask

  // Every output of one instance at its reset value.
  task automatic checkResetState(input int d);
    checkOutput($sformatf("rst_in_ready_u%0d", d), obsReady[d], 1'b0);
    checkOutput($sformatf("rst_wr_en_u%0d", d), obsWrEn[d], 1'b0);
    checkOutput($sformatf("rst_wr_addr_u%0d", d), obsAddr[d], 8'h0);
    checkOutput($sformatf("rst_wr_data_u%0d", d), obsData[d], 32'h0);
    checkOutput($sformatf("rst_wr_bytes_u%0d", d), obsBytes[d], 3'h0);
    checkOutput($sformatf("rst_hsync_u%0d", d), obsHs[d], 1'b0);
    checkOutput($sformatf("rst_vsync_u%0d", d), obsVs[d], 1'b0);
    checkOutput($sformatf("rst_done_u%0d", d), obsDone[d], 1'b0);
    checkOutput($sformatf("rst_overflow_u%0d", d), obsOvf[d], 1'b0);
  endtask

  // Output monitor: pops the scoreboard whenever a write or sync pulse appears.
  wrExp_t   monW;
  syncExp_t monS;
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (obsWrEn[d] === 1'b1) begin
        if (wrQ.size() > 0 && wrQ[0].dut == d) begin
          monW = wrQ.pop_front();
          checkOutput($sformatf("wr_cycle_u%0d", d), cyc, monW.due);
          checkOutput($sformatf("wr_addr_u%0d", d), obsAddr[d], monW.addr);
          checkOutput($sformatf("wr_data_u%0d", d), obsData[d], monW.data);
          checkOutput($sformatf("wr_bytes_u%0d", d), obsBytes[d], monW.bytes);
          checkOutput($sformatf("wr_done_u%0d", d), obsDone[d], monW.done);
          checkOutput($sformatf("wr_overflow_u%0d", d), obsOvf[d], monW.ovf);
        end else begin
          checkOutput($sformatf("unexpected_wr_u%0d", d), 1, 0);
        end
      end
      if (obsHs[d] === 1'b1 || obsVs[d] === 1'b1) begin
        if (syQ.size() > 0 && syQ[0].dut == d) begin
          monS = syQ.pop_front();
          checkOutput($sformatf("sync_cycle_u%0d", d), cyc, monS.due);
          checkOutput($sformatf("hsync_u%0d", d), obsHs[d], 1'b1);
          checkOutput($sformatf("vsync_u%0d", d), obsVs[d], monS.vs);
        end else begin
          checkOutput($sformatf("unexpected_sync_u%0d", d), {obsHs[d], obsVs[d]}, 2'b00);
        end
      end
    end
    if (wrQ.size() > 0 && wrQ[0].due < cyc) begin
      monW = wrQ.pop_front();
      checkOutput($sformatf("missed_wr_u%0d", monW.dut), 0, 1);
    end
    if (syQ.size() > 0 && syQ[0].due < cyc) begin
      monS = syQ.pop_front();
      checkOutput($sformatf("missed_sync_u%0d", monS.dut), 0, 1);
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    int  acc;
    int  guard;
    bit  taken;
    for (int d = 0; d < 4; d++) begin
      inValid[d] = 1'b0;
      inLast[d]  = 1'b0;
      inData[d]  = 8'h00;
      clearIn[d] = 1'b0;
      modelReset(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) checkResetState(d);
    reset = 1'b1;
    idle(2);

    $display("[TB] LSB-first packing of 0x01..0x08");
    streamBytes(0, 8'h01, 8, 1'b0);
    idle(3);
    pulseClear(0);
    idle(1);

    $display("[TB] MSB-first partial flush with in_last");
    streamBytes(1, 8'hAA, 1, 1'b0);
    streamBytes(1, 8'hBB, 1, 1'b0);
    streamBytes(1, 8'hCC, 1, 1'b1);
    idle(2);
    checkOutput("done_level_u1", obsDone[1], 1'b1);
    applyStimulus(1, 8'hDD, 1'b0, 1'b1, taken);
    idle(1);

    $display("[TB] stop at end of buffer, then wrap");
    streamBytes(2, 8'h31, 6, 1'b0);
    idle(2);
    checkOutput("overflow_sticky_u2", obsOvf[2], 1'b1);
    streamBytes(3, 8'h51, 6, 1'b0);
    idle(2);
    checkOutput("overflow_wrap_u3", obsOvf[3], 1'b0);

    $display("[TB] sync pulses with irregular valid");
    acc   = 0;
    guard = 0;
    while (acc < 6 && guard < 200) begin
      applyStimulus(0, 8'h10 + 8'(acc), 1'b0, 1'($urandom_range(0, 1)), taken);
      if (taken) acc++;
      guard++;
    end
    checkOutput("sync_bytes_accepted", acc, 6);
    idle(3);

    $display("[TB] clear drops a partial word");
    pulseClear(0);
    streamBytes(0, 8'hA1, 2, 1'b0);
    pulseClear(0);
    streamBytes(0, 8'hB1, 4, 1'b0);
    pulseClear(0);
    idle(2);

    $display("[TB] clear releases DONE and FULL");
    pulseClear(1);
    idle(1);
    checkOutput("done_after_clear_u1", obsDone[1], 1'b0);
    streamBytes(1, 8'hAA, 4, 1'b0);
    streamBytes(1, 8'h11, 1, 1'b1);
    pulseClear(2);
    idle(1);
    checkOutput("overflow_after_clear_u2", obsOvf[2], 1'b0);
    streamBytes(2, 8'h41, 2, 1'b0);
    idle(2);

    $display("[TB] asynchronous reset mid-word");
    streamBytes(0, 8'hC1, 2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) checkResetState(d);
    for (int d = 0; d < 4; d++) modelReset(d);
    idle(2);
    reset = 1'b1;
    idle(1);
    streamBytes(0, 8'hD1, 4, 1'b0);
    idle(3);

    checkOutput("write_queue_drained", wrQ.size(), 0);
    checkOutput("sync_queue_drained", syQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
